// File: rtl/doe_cipher_shim_if.sv
`default_nettype none
// ============================================================================
// doe_cipher_shim_if: sequencer-side and core-side signals of the cipher shim
// Revision: 1.0
// ============================================================================
interface doe_cipher_shim_if #(
  parameter int SRC_WIDTH  = 128,
  parameter int DEST_WIDTH = 128
);
  logic                  zeroize;
  logic                  src_write_en;
  logic [SRC_WIDTH-1:0]  src_write_data;
  logic                  doe_init;
  logic                  doe_next;
  logic                  init_done;
  logic                  dest_data_avail;
  logic [DEST_WIDTH-1:0] dest_data;
  logic                  core_init_req;
  logic                  core_next_req;
  logic [SRC_WIDTH-1:0]  core_block;
  logic                  core_ready;
  logic                  core_done;
  logic [DEST_WIDTH-1:0] core_result;
  logic                  shim_error;

  // Environment view: drives sequencer pulses and core responses.
  modport master (
    output zeroize, src_write_en, src_write_data, doe_init, doe_next,
    output core_ready, core_done, core_result,
    input  init_done, dest_data_avail, dest_data,
    input  core_init_req, core_next_req, core_block, shim_error
  );

  modport slave (
    input  zeroize, src_write_en, src_write_data, doe_init, doe_next,
    input  core_ready, core_done, core_result,
    output init_done, dest_data_avail, dest_data,
    output core_init_req, core_next_req, core_block, shim_error
  );
endinterface
`default_nettype wire

// File: rtl/doe_cipher_shim.sv
`default_nettype none
// ============================================================================
// doe_cipher_shim: pulse-to-valid/ready adapter with result capture and watchdog
// Revision: 1.0
// ============================================================================
module doe_cipher_shim #(
  parameter int SRC_WIDTH      = 128,
  parameter int DEST_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic        clk,
  input  wire logic        rst_b,
  doe_cipher_shim_if.slave bus
);

  localparam int c_wd_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_REQ  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_READY     = 3'd3,
    ST_NEXT_REQ  = 3'd4,
    ST_NEXT_WAIT = 3'd5
  } state_t;

  state_t                r_state,       w_state_nxt;
  logic                  r_key_loaded,  w_key_nxt;
  logic [SRC_WIDTH-1:0]  r_block,       w_block_nxt;
  logic                  r_block_valid, w_block_valid_nxt;
  logic [SRC_WIDTH-1:0]  r_req_block,   w_req_block_nxt;
  logic [DEST_WIDTH-1:0] r_dest_data,   w_dest_nxt;
  logic                  r_avail,       w_avail_nxt;
  logic                  r_error,       w_error_nxt;
  logic [c_wd_w-1:0]     r_wd_cnt,      w_wd_nxt;
  logic                  r_init_done;
  logic                  w_err_set;
  logic                  w_err_clr;
  logic                  w_open;
  logic                  w_expire;

  assign w_open   = (r_state == ST_IDLE) || (r_state == ST_READY);
  assign w_expire = (r_wd_cnt == c_wd_last);

  always_comb begin
    w_state_nxt       = r_state;
    w_key_nxt         = r_key_loaded;
    w_block_nxt       = r_block;
    w_block_valid_nxt = r_block_valid;
    w_req_block_nxt   = r_req_block;
    w_dest_nxt        = r_dest_data;
    w_avail_nxt       = r_avail;
    w_wd_nxt          = r_wd_cnt;
    w_err_set         = 1'b0;
    w_err_clr         = 1'b0;

    if (bus.src_write_en) begin
      if (w_open) begin
        w_block_nxt       = bus.src_write_data;
        w_block_valid_nxt = 1'b1;
      end else begin
        w_err_set = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE, ST_READY: begin
        if (bus.doe_init) begin
          w_state_nxt = ST_INIT_REQ;
          w_key_nxt   = 1'b0;
          w_avail_nxt = 1'b0;
          w_err_clr   = 1'b1;
          if (bus.doe_next) begin
            w_err_set = 1'b1;
          end
        end else if (bus.doe_next) begin
          if ((r_state == ST_READY) && r_block_valid) begin
            // Snapshot the current block so a same-cycle write cannot alter the request.
            w_state_nxt     = ST_NEXT_REQ;
            w_avail_nxt     = 1'b0;
            w_req_block_nxt = r_block;
            if (!bus.src_write_en) begin
              w_block_valid_nxt = 1'b0;
            end
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_INIT_REQ, ST_NEXT_REQ: begin
        if (bus.doe_init || bus.doe_next) begin
          w_err_set = 1'b1;
        end
        if (bus.core_ready) begin
          w_state_nxt = (r_state == ST_INIT_REQ) ? ST_INIT_WAIT : ST_NEXT_WAIT;
          w_wd_nxt    = '0;
        end
      end
      ST_INIT_WAIT, ST_NEXT_WAIT: begin
        if (bus.doe_init || bus.doe_next) begin
          w_err_set = 1'b1;
        end
        if (bus.core_done) begin
          w_state_nxt = ST_READY;
          if (r_state == ST_INIT_WAIT) begin
            w_key_nxt = 1'b1;
          end else if (!r_avail) begin
            w_dest_nxt  = bus.core_result;
            w_avail_nxt = 1'b1;
          end
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_key_nxt   = 1'b0;
          w_err_set   = 1'b1;
        end else begin
          w_wd_nxt = r_wd_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_key_nxt   = 1'b0;
      end
    endcase

    w_error_nxt = w_err_set ? 1'b1 : (w_err_clr ? 1'b0 : r_error);
  end

  always_ff @(posedge clk) begin
    if (!rst_b || bus.zeroize) begin
      r_state       <= ST_IDLE;
      r_key_loaded  <= 1'b0;
      r_block       <= '0;
      r_block_valid <= 1'b0;
      r_req_block   <= '0;
      r_dest_data   <= '0;
      r_avail       <= 1'b0;
      r_error       <= 1'b0;
      r_wd_cnt      <= '0;
      r_init_done   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_key_loaded  <= w_key_nxt;
      r_block       <= w_block_nxt;
      r_block_valid <= w_block_valid_nxt;
      r_req_block   <= w_req_block_nxt;
      r_dest_data   <= w_dest_nxt;
      r_avail       <= w_avail_nxt;
      r_error       <= w_error_nxt;
      r_wd_cnt      <= w_wd_nxt;
      r_init_done   <= (w_state_nxt == ST_READY) && w_key_nxt;
    end
  end

  assign bus.init_done       = r_init_done;
  assign bus.dest_data_avail = r_avail;
  assign bus.dest_data       = r_dest_data;
  assign bus.core_init_req   = (r_state == ST_INIT_REQ);
  assign bus.core_next_req   = (r_state == ST_NEXT_REQ);
  assign bus.core_block      = (r_state == ST_NEXT_REQ) ? r_req_block : '0;
  assign bus.shim_error      = r_error;

endmodule
`default_nettype wire

// File: doc/doe_cipher_shim.md
Name: doe_cipher_shim

Overview:
- Handshake adapter between the DOE sequencer and the block-cipher core.
- Converts the sequencer's one-cycle init/next pulses and block writes into a valid/ready request to the core. Captures the core result.
- Presents level init_done / dest_data_avail / dest_data to the sequencer.
- Adds protocol checking and a response watchdog.

Parameters:
- SRC_WIDTH, 128, width of the input block written by the sequencer.
- DEST_WIDTH, 128, width of the core result; must be a multiple of 32.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for core_done after request acceptance.

Ports:
- clk  input  1  clock
- rst_b  input  1  synchronous, active-low reset
- zeroize  input  1  synchronous clear pulse
- src_write_en  input  1  latch src_write_data into the block register
- src_write_data  input  SRC_WIDTH  next input block
- doe_init  input  1  key-expansion request pulse
- doe_next  input  1  process-block request pulse
- init_done  output  1  core keyed and idle; shim can accept doe_next
- dest_data_avail  output  1  dest_data holds a fresh result
- dest_data  output  DEST_WIDTH  result; dword i = bits [32i+31:32i]
- core_init_req  output  1  init request valid
- core_next_req  output  1  next request valid
- core_block  output  SRC_WIDTH  block presented with core_next_req
- core_ready  input  1  core accepts request this cycle
- core_done  input  1  one-cycle completion pulse (init or next)
- core_result  input  DEST_WIDTH  valid only with core_done after a next request
- shim_error  output  1  sticky protocol/timeout error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_b is synchronous, active-low.
- Reset values:
  - all outputs 0
  - state IDLE
  - block_reg 0, block_valid 0, key_loaded 0
  - timeout counter 0
- zeroize: same effect as reset on the next edge. It overrides every other input that cycle; an in-flight core request drops immediately.
- States: IDLE, INIT_REQ, INIT_WAIT, READY, NEXT_REQ, NEXT_WAIT.
- IDLE/READY + doe_init → INIT_REQ:
  - clear key_loaded, dest_data_avail, shim_error
  - init_done drops the next cycle
- INIT_REQ:
  - core_init_req=1, held until the cycle core_ready=1, then → INIT_WAIT
  - requests never drop while unaccepted
- INIT_WAIT: core_done → READY, set key_loaded.
- READY:
  - init_done = key_loaded and state==READY, registered; first high the cycle after core_done
  - doe_next with block_valid=1 → NEXT_REQ; clear dest_data_avail
  - doe_next with block_valid=0: ignored, set shim_error
- NEXT_REQ:
  - core_next_req=1, core_block=block_reg, held until core_ready → NEXT_WAIT
  - clear block_valid on acceptance
- NEXT_WAIT: core_done →
  - dest_data<=core_result
  - dest_data_avail<=1 (visible next cycle)
  - → READY
- init_done is 0 in all states except READY. So after doe_next, the sequencer never sees init_done=1 with stale avail=0.
- dest_data and dest_data_avail:
  - held stable until the next accepted doe_init/doe_next, or zeroize
  - a result is never overwritten while avail=1
- src_write_en:
  - accepted in IDLE and READY; block_reg<=src_write_data, block_valid<=1 next cycle
  - in REQ/WAIT states: ignored, shim_error set
- Same-cycle rules:
  - src_write_en together with doe_next: doe_next uses the old block_reg/block_valid; the write still takes effect
  - doe_init together with doe_next: init wins, next ignored, shim_error set
- doe_init/doe_next in any REQ/WAIT state: ignored, shim_error set.
- doe_next in IDLE: ignored, shim_error set.
- Watchdog:
  - counter clears on request acceptance and increments each cycle in INIT_WAIT/NEXT_WAIT
  - reaching TIMEOUT_CYCLES → IDLE, key_loaded=0, shim_error=1
  - core_done in the same cycle as expiry wins (normal completion)
- core_done outside a WAIT state: ignored, no error.
- shim_error clears only on rst_b, zeroize, or an accepted doe_init.

Test Plan:
- Full flow: doe_init; core_ready on the 3rd request cycle; core_done 5 cycles later → init_done=1 the cycle after. Then src_write 0x0011..FF, doe_next, core_done with result 0xDEADBEEF_… → dest_data_avail=1, dest_data matches, init_done=1 together, shim_error=0.
- Back-to-back blocks: four src_write/doe_next cycles → avail drops the cycle after each doe_next. Each result is captured exactly once and in order. core_block equals each written block.
- Protocol errors:
  - doe_next with no prior src_write → shim_error=1, no core_next_req
  - src_write during NEXT_WAIT → block_reg unchanged, shim_error=1
  - next doe_init → shim_error=0
- Timeout: TIMEOUT_CYCLES=16, withhold core_done after init acceptance → on the 16th wait cycle: state IDLE, init_done=0, shim_error=1. Repeat with core_done on the 16th cycle → READY, no error.
- Zeroize during NEXT_REQ with core_ready=0 → next cycle core_next_req=0, dest_data=0, avail=0, init_done=0. A subsequent doe_init works normally.
- Synchronous reset: rst_b low for 1 cycle mid-NEXT_WAIT → all outputs 0 at the following edge. A late core_done is ignored.
